mem_port_arbiter: RTL and testbench

- Two-requester arbiter that shares one downstream memory port (dfp) between instruction fetch (port 0) and the load/store unit (port 1).
- Both upstream ports use the core's ufp pulse protocol:
  - Request = one cycle with nonzero rmask or wmask.
  - Response = one-cycle resp.
- Buffers one request per port, grants round-robin on conflict, launches one transaction at a time, and routes the response back to the owner.

---
 rtl/mem_port_arbiter_if.sv | 18 +
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Memory port bundle shared by the upstream ufp ports and the downstream dfp port.
// master drives the request side; slave returns data and the response pulse.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int MW = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] addr;
  logic [MW-1:0]         rmask;
  logic [MW-1:0]         wmask;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  resp;

  modport master (output addr, rmask, wmask, wdata, input rdata, resp);
  modport slave  (input addr, rmask, wmask, wdata, output rdata, resp);
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one downstream memory port between fetch (port 0)
// and the LSU (port 1); one request buffered per port, one transaction in flight.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    ufp0,
  mem_port_arbiter_if.slave    ufp1,
  mem_port_arbiter_if.master   dfp,
  output logic                 busy
);
  localparam int MW = DATA_WIDTH / 8;

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_d;

  logic [ADDR_WIDTH-1:0] live_addr  [2];
  logic [MW-1:0]         live_rmask [2];
  logic [MW-1:0]         live_wmask [2];
  logic [DATA_WIDTH-1:0] live_wdata [2];
  logic [1:0]            req;

  logic [1:0]            pend_v;
  logic [ADDR_WIDTH-1:0] pend_addr  [2];
  logic [MW-1:0]         pend_rmask [2];
  logic [MW-1:0]         pend_wmask [2];
  logic [DATA_WIDTH-1:0] pend_wdata [2];

  logic                  owner, last_grant;
  logic [ADDR_WIDTH-1:0] dfp_addr_q;
  logic [MW-1:0]         dfp_rmask_q, dfp_wmask_q;
  logic [DATA_WIDTH-1:0] dfp_wdata_q;

  logic [1:0]            cand;
  logic [1:0]            win_oh;
  logic [1:0]            capture;
  logic                  win, launch;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [MW-1:0]         sel_rmask, sel_wmask;
  logic [DATA_WIDTH-1:0] sel_wdata;

  always_comb begin
    live_addr[0]  = ufp0.addr;   live_addr[1]  = ufp1.addr;
    live_rmask[0] = ufp0.rmask;  live_rmask[1] = ufp1.rmask;
    live_wmask[0] = ufp0.wmask;  live_wmask[1] = ufp1.wmask;
    live_wdata[0] = ufp0.wdata;  live_wdata[1] = ufp1.wdata;
    req[0] = (|ufp0.rmask) | (|ufp0.wmask);
    req[1] = (|ufp1.rmask) | (|ufp1.wmask);
  end

  // Arbitration runs whenever the port is free: in IDLE, or in the response cycle.
  always_comb begin
    cand   = pend_v | req;
    launch = ((state == IDLE) || dfp.resp) && (|cand);
    if (&cand) win = ~last_grant;
    else       win = cand[1];
    win_oh = {win, ~win};
    // A buffered entry is older than anything on the live inputs.
    sel_addr  = pend_v[win] ? pend_addr[win]  : live_addr[win];
    sel_rmask = pend_v[win] ? pend_rmask[win] : live_rmask[win];
    sel_wmask = pend_v[win] ? pend_wmask[win] : live_wmask[win];
    sel_wdata = pend_v[win] ? pend_wdata[win] : live_wdata[win];
    // Drop extra requests: one already buffered, or the owner re-requesting mid-flight.
    for (int unsigned i = 0; i < 2; i++) begin
      capture[i] = req[i] && !pend_v[i] &&
                   !((state == BUSY) && (owner == i[0]) && !dfp.resp);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (launch) state_d = BUSY;
      BUSY:    if (dfp.resp && !launch) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ufp0.rdata = dfp.rdata;
    ufp1.rdata = dfp.rdata;
    ufp0.resp  = dfp.resp && (state == BUSY) && !owner;
    ufp1.resp  = dfp.resp && (state == BUSY) && owner;
    busy       = (state == BUSY);
    dfp.addr   = dfp_addr_q;
    dfp.rmask  = dfp_rmask_q;
    dfp.wmask  = dfp_wmask_q;
    dfp.wdata  = dfp_wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        pend_addr[i]  <= '0;
        pend_rmask[i] <= '0;
        pend_wmask[i] <= '0;
        pend_wdata[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (launch && win_oh[i]) begin
          pend_v[i] <= 1'b0;
        end else if (capture[i]) begin
          pend_v[i]     <= 1'b1;
          pend_addr[i]  <= live_addr[i];
          pend_rmask[i] <= live_rmask[i];
          pend_wmask[i] <= live_wmask[i];
          pend_wdata[i] <= live_wdata[i];
        end
      end
    end
  end

  // Masks pulse for one cycle; address and data hold until the next launch.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= 1'b0;
      last_grant  <= 1'b0;
      dfp_addr_q  <= '0;
      dfp_rmask_q <= '0;
      dfp_wmask_q <= '0;
      dfp_wdata_q <= '0;
    end else if (launch) begin
      owner       <= win;
      last_grant  <= win;
      dfp_addr_q  <= sel_addr;
      dfp_rmask_q <= sel_rmask;
      dfp_wmask_q <= sel_wmask;
      dfp_wdata_q <= sel_wdata;
    end else begin
      dfp_rmask_q <= '0;
      dfp_wmask_q <= '0;
    end
  end

  a_ufp0_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    !((|ufp0.rmask) && (|ufp0.wmask)));
  a_ufp1_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    !((|ufp1.rmask) && (|ufp1.wmask)));
  a_no_req_while_pending: assert property (@(posedge clk) disable iff (rst)
    !(|(req & pend_v)));
  a_no_req_while_outstanding: assert property (@(posedge clk) disable iff (rst)
    !((state == BUSY) && !dfp.resp && req[owner]));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs change 1ns after posedge,
// outputs are sampled 1ns later.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) u0_if ();
  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) u1_if ();
  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) d_if ();

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .ufp0 (u0_if.slave),
    .ufp1 (u1_if.slave),
    .dfp  (d_if.master),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    u0_if.rmask = '0; u0_if.wmask = '0;
    u1_if.rmask = '0; u1_if.wmask = '0;
    d_if.resp   = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int exp_p;
    int idx;
    logic [31:0] exp_addr;

    u0_if.addr = '0; u0_if.rmask = '0; u0_if.wmask = '0; u0_if.wdata = '0;
    u1_if.addr = '0; u1_if.rmask = '0; u1_if.wmask = '0; u1_if.wdata = '0;
    d_if.rdata = '0; d_if.resp = 1'b0;

    reset_dut();
    #1;
    check("rst_busy",  64'(busy), 64'h0);
    check("rst_rmask", 64'(d_if.rmask), 64'h0);
    check("rst_wmask", 64'(d_if.wmask), 64'h0);
    check("rst_addr",  64'(d_if.addr), 64'h0);
    check("rst_wdata", 64'(d_if.wdata), 64'h0);
    check("rst_resp0", 64'(u0_if.resp), 64'h0);
    check("rst_resp1", 64'(u1_if.resp), 64'h0);

    // Single read: cycle 0 request, cycle 1 pulse, cycle 3 response
    u0_if.rmask = 4'hF; u0_if.addr = 32'h1ECEB000;
    #1;
    check("sr_c0_rmask", 64'(d_if.rmask), 64'h0);
    next_cycle(); #1;
    check("sr_c1_rmask", 64'(d_if.rmask), 64'hF);
    check("sr_c1_addr",  64'(d_if.addr), 64'h1ECEB000);
    check("sr_c1_busy",  64'(busy), 64'h1);
    next_cycle(); #1;
    check("sr_c2_rmask", 64'(d_if.rmask), 64'h0);
    check("sr_c2_addr",  64'(d_if.addr), 64'h1ECEB000);
    next_cycle();
    d_if.resp = 1'b1; d_if.rdata = 32'h00000013;
    #1;
    check("sr_c3_resp0", 64'(u0_if.resp), 64'h1);
    check("sr_c3_rdata0", 64'(u0_if.rdata), 64'h13);
    check("sr_c3_resp1", 64'(u1_if.resp), 64'h0);
    next_cycle(); #1;
    check("sr_c4_busy", 64'(busy), 64'h0);
    check("sr_c4_resp0", 64'(u0_if.resp), 64'h0);

    // Simultaneous requests after reset, then back-to-back on port 0
    reset_dut();
    u0_if.rmask = 4'hF; u0_if.addr = 32'h1000;
    u1_if.wmask = 4'hF; u1_if.addr = 32'h2000; u1_if.wdata = 32'hDEADBEEF;
    next_cycle(); #1;
    check("sim_w_wmask", 64'(d_if.wmask), 64'hF);
    check("sim_w_rmask", 64'(d_if.rmask), 64'h0);
    check("sim_w_addr",  64'(d_if.addr), 64'h2000);
    check("sim_w_wdata", 64'(d_if.wdata), 64'hDEADBEEF);
    next_cycle();
    d_if.resp = 1'b1; d_if.rdata = 32'h0;
    #1;
    check("sim_resp1", 64'(u1_if.resp), 64'h1);
    check("sim_resp0_quiet", 64'(u0_if.resp), 64'h0);
    next_cycle(); #1;
    check("sim_r_rmask", 64'(d_if.rmask), 64'hF);
    check("sim_r_addr",  64'(d_if.addr), 64'h1000);
    check("sim_r_busy",  64'(busy), 64'h1);
    next_cycle();
    d_if.resp = 1'b1; d_if.rdata = 32'h0000CAFE;
    u0_if.rmask = 4'hF; u0_if.addr = 32'h1004;
    #1;
    check("sim_resp0", 64'(u0_if.resp), 64'h1);
    check("sim_rdata0", 64'(u0_if.rdata), 64'hCAFE);
    check("sim_resp1_quiet", 64'(u1_if.resp), 64'h0);
    next_cycle(); #1;
    check("b2b_rmask", 64'(d_if.rmask), 64'hF);
    check("b2b_addr",  64'(d_if.addr), 64'h1004);
    check("b2b_busy",  64'(busy), 64'h1);
    next_cycle();
    d_if.resp = 1'b1;
    #1;
    check("b2b_resp0", 64'(u0_if.resp), 64'h1);
    next_cycle(); #1;
    check("b2b_idle", 64'(busy), 64'h0);

    // Request while busy: port 1 arrives two cycles into a port-0 transaction
    u0_if.rmask = 4'hF; u0_if.addr = 32'h5000;
    next_cycle(); #1;
    check("rwb_p0_addr", 64'(d_if.addr), 64'h5000);
    next_cycle();
    u1_if.rmask = 4'hF; u1_if.addr = 32'h3000;
    #1;
    check("rwb_c2_rmask", 64'(d_if.rmask), 64'h0);
    next_cycle(); #1;
    check("rwb_c3_held", 64'(d_if.rmask), 64'h0);
    check("rwb_c3_busy", 64'(busy), 64'h1);
    next_cycle();
    d_if.resp = 1'b1; d_if.rdata = 32'h55;
    #1;
    check("rwb_resp0", 64'(u0_if.resp), 64'h1);
    check("rwb_resp1_quiet", 64'(u1_if.resp), 64'h0);
    next_cycle(); #1;
    check("rwb_p1_rmask", 64'(d_if.rmask), 64'hF);
    check("rwb_p1_addr",  64'(d_if.addr), 64'h3000);
    next_cycle();
    d_if.resp = 1'b1; d_if.rdata = 32'h33;
    #1;
    check("rwb_resp1", 64'(u1_if.resp), 64'h1);
    check("rwb_rdata1", 64'(u1_if.rdata), 64'h33);
    next_cycle(); #1;
    check("rwb_idle", 64'(busy), 64'h0);

    // Fairness: both ports re-request on every response, grants alternate 1,0,1,0...
    reset_dut();
    u0_if.rmask = 4'hF; u0_if.addr = 32'h4000;
    u1_if.rmask = 4'hF; u1_if.addr = 32'h8000;
    for (int k = 0; k < 10; k++) begin
      exp_p    = (k % 2 == 0) ? 1 : 0;
      idx      = k / 2;
      exp_addr = (exp_p == 1 ? 32'h8000 : 32'h4000) + 32'(4 * idx);
      next_cycle(); #1;
      check("fair_rmask", 64'(d_if.rmask), 64'hF);
      check("fair_addr",  64'(d_if.addr), 64'(exp_addr));
      next_cycle();
      d_if.resp = 1'b1; d_if.rdata = 32'(k);
      #1;
      check("fair_resp0", 64'(u0_if.resp), (exp_p == 0) ? 64'h1 : 64'h0);
      check("fair_resp1", 64'(u1_if.resp), (exp_p == 1) ? 64'h1 : 64'h0);
      if (k <= 7) begin
        if (exp_p == 1) begin
          u1_if.rmask = 4'hF; u1_if.addr = 32'h8000 + 32'(4 * (idx + 1));
        end else begin
          u0_if.rmask = 4'hF; u0_if.addr = 32'h4000 + 32'(4 * (idx + 1));
        end
      end
    end
    next_cycle(); #1;
    check("fair_idle", 64'(busy), 64'h0);
    check("fair_rmask_end", 64'(d_if.rmask), 64'h0);

    // Reset mid-transaction, then a stale response
    u0_if.rmask = 4'hF; u0_if.addr = 32'h6000;
    next_cycle(); #1;
    check("rmo_launch", 64'(d_if.rmask), 64'hF);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    check("rmo_busy", 64'(busy), 64'h0);
    check("rmo_rmask", 64'(d_if.rmask), 64'h0);
    next_cycle();
    d_if.resp = 1'b1; d_if.rdata = 32'hBAD;
    #1;
    check("rmo_stale_resp0", 64'(u0_if.resp), 64'h0);
    check("rmo_stale_resp1", 64'(u1_if.resp), 64'h0);
    check("rmo_stale_busy",  64'(busy), 64'h0);
    next_cycle();
    u0_if.rmask = 4'hF; u0_if.addr = 32'h7000;
    #1;
    check("rmo_quiet_wmask", 64'(d_if.wmask), 64'h0);
    next_cycle(); #1;
    check("rmo_new_rmask", 64'(d_if.rmask), 64'hF);
    check("rmo_new_addr",  64'(d_if.addr), 64'h7000);
    next_cycle();
    d_if.resp = 1'b1; d_if.rdata = 32'h77;
    #1;
    check("rmo_new_resp0", 64'(u0_if.resp), 64'h1);
    check("rmo_new_rdata", 64'(u0_if.rdata), 64'h77);
    next_cycle(); #1;
    check("rmo_new_idle", 64'(busy), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
